// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor. A WIDTH-bit operand pair is
// processed SLICE bits per clock through a ripple chain of 1-bit full-adder
// cells, with the carry registered between slices. start/done handshake.
// Optional feature: define SERIAL_ADDER_ERR_EN to add the sticky 'err'
// output, set when start is requested while an operation is running.
module serial_adder #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_in,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] S,
   output logic             C_out,
   output logic             Ofl
`ifdef SERIAL_ADDER_ERR_EN
   ,
   output logic             err
`endif
);

   localparam int            N    = WIDTH / SLICE;
   localparam int            CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   // Reject illegal geometries at elaboration time.
   if (WIDTH < 1 || SLICE < 1 || SLICE > WIDTH || (WIDTH % SLICE) != 0) begin : g_param_check
      $error("serial_adder: WIDTH must be a positive multiple of SLICE");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    counter;
   logic             carry;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;     // already inverted in subtract mode
   logic [WIDTH-1:0] work;

   logic [SLICE-1:0] a_slice;
   logic [SLICE-1:0] b_slice;
   logic [SLICE-1:0] sum_slice;
   logic             slice_cout;
   logic             msb_cin;
   logic [WIDTH-1:0] next_work;
   logic             c;

   // Ripple the current slice through SLICE full-adder cells from the registered carry.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      a_slice   = a_reg[counter*SLICE +: SLICE];
      b_slice   = b_reg[counter*SLICE +: SLICE];
      sum_slice = '0;
      msb_cin   = 1'b0;
      c         = carry;
      // NOTE: blocking assignments model the ripple: each cell must see the
      // carry produced by the previous cell in the same evaluation.
      for (int i = 0; i < SLICE; i++) begin
         sum_slice[i] = a_slice[i] ^ b_slice[i] ^ c;
         // In the last slice this is the carry into the word MSB.
         if (i == SLICE - 1) msb_cin = c;
         c = (a_slice[i] & b_slice[i]) | (c & (a_slice[i] ^ b_slice[i]));
      end
      slice_cout = c;
      next_work  = work;
      next_work[counter*SLICE +: SLICE] = sum_slice;
   end

   // Control FSM and result registers; rst takes priority over start.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      if (rst) begin
         state   <= IDLE;
         counter <= '0;
         carry   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         S       <= '0;
         C_out   <= 1'b0;
         Ofl     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  carry   <= sub ? ~C_in : C_in;
                  counter <= '0;
                  busy    <= 1'b1;
                  state   <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               carry   <= slice_cout;
               counter <= counter + CW'(1);
               if (counter == LAST) begin
                  counter <= '0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= DONE;
                  S       <= next_work;
                  C_out   <= slice_cout;
                  Ofl     <= msb_cin ^ slice_cout;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Operand capture on accept and slice-by-slice fill of the working sum.
   always_ff @(posedge clk) begin
      // NOTE: pure data registers carry no reset; the FSM decides when they are meaningful.
      if (start && state != RUN) begin
         a_reg <= A;
         b_reg <= sub ? ~B : B;
      end
      if (state == RUN) work <= next_work;
   end

`ifdef SERIAL_ADDER_ERR_EN
   // Sticky protocol error: a start request arrived while an operation was running.
   always_ff @(posedge clk) begin
      if (rst)                       err <= 1'b0;
      else if (start && state == RUN) err <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: self-checking bench for serial_adder (WIDTH=16, SLICE=4).
// Fixed vectors from a table, hand-written protocol sequences, and random
// operations compared against an arithmetic reference model.
module tb_serial_adder;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int N     = WIDTH / SLICE;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A;
   logic [15:0] B;
   logic        C_in;
   logic        sub;
   logic        busy;
   logic        done;
   logic [15:0] S;
   logic        C_out;
   logic        Ofl;
`ifdef SERIAL_ADDER_ERR_EN
   logic        err;
`endif

   serial_adder #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .C_in  (C_in),
      .sub   (sub),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .C_out (C_out),
      .Ofl   (Ofl)
`ifdef SERIAL_ADDER_ERR_EN
      ,
      .err   (err)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Expected value of the last completed result (held while a new op runs).
   logic [15:0] hold_s  = 16'h0;
   logic        hold_co = 1'b0;
   logic        hold_of = 1'b0;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        ci;
      logic        sb;
      logic [15:0] s;
      logic        co;
      logic        of;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                 input logic ci, input logic sb,
                                 output logic [15:0] s, output logic co, output logic of);
      int ua, ub, uc, sa, sbv, r, u;
      ua  = int'(a);
      ub  = int'(b);
      uc  = ci ? 1 : 0;
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      if (!sb) begin
         u  = ua + ub + uc;
         co = (u > 65535);
         r  = sa + sbv + uc;
      end else begin
         u  = ua - ub - uc;
         co = (ua >= ub + uc);      // no borrow
         r  = sa - sbv - uc;
      end
      s  = 16'(u);
      of = (r > 32767) || (r < -32768);
   endfunction

   // Call at a negedge; returns at the negedge of the DONE cycle.
   task automatic run_and_check(input string name, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, input logic sb,
                                input logic [15:0] es, input logic eco, input logic eof);
      int lat;
      int busy_n;
      A = a; B = b; C_in = ci; sub = sb; start = 1'b1;
      @(posedge clk);                        // E0
      @(negedge clk);
      start = 1'b0;
      A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom); sub = 1'($urandom);
      check({name, ":S_held"}, 32'(S), 32'(hold_s));
      check({name, ":C_out_held"}, 32'(C_out), 32'(hold_co));
      lat    = 0;
      busy_n = 0;
      while (!done && lat < 20) begin
         if (busy) busy_n++;
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      // Edges from E0 (inclusive) up to the edge that raises done.
      check({name, ":start_to_done_edges"}, 32'(lat + 1), 32'(N + 1));
      check({name, ":busy_cycles"}, 32'(busy_n), 32'(N));
      check({name, ":S"}, 32'(S), 32'(es));
      check({name, ":C_out"}, 32'(C_out), 32'(eco));
      check({name, ":Ofl"}, 32'(Ofl), 32'(eof));
      hold_s  = es;
      hold_co = eco;
      hold_of = eof;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n_done;
      logic [15:0] got_s;
      logic [15:0] ra, rb, ms;
      logic        rci, rsb, mco, mof;

      vecs[0] = '{16'h1234, 16'h0FCD, 1'b1, 1'b0, 16'h2202, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

      // Reset held two cycles while start is asserted with random operands.
      rst = 1'b1; start = 1'b1;
      A = 16'($urandom); B = 16'($urandom); C_in = 1'($urandom); sub = 1'($urandom);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst:busy", 32'(busy), 32'(0));
      check("rst:done", 32'(done), 32'(0));
      check("rst:S", 32'(S), 32'(0));
      check("rst:C_out", 32'(C_out), 32'(0));
      check("rst:Ofl", 32'(Ofl), 32'(0));
`ifdef SERIAL_ADDER_ERR_EN
      check("rst:err", 32'(err), 32'(0));
`endif
      rst = 1'b0; start = 1'b0;
      @(negedge clk);

      // Table vectors back-to-back: each start lands in the previous DONE cycle.
      for (int i = 0; i < 5; i++)
         run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb,
                       vecs[i].s, vecs[i].co, vecs[i].of);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 32'(0));
      check("S_hold_idle", 32'(S), 32'(hold_s));

      // Start during RUN must be ignored.
      A = 16'h0001; B = 16'h0001; C_in = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);            // first RUN cycle
      start = 1'b0;
      @(posedge clk); @(negedge clk);            // second RUN cycle
      A = 16'hAAAA; B = 16'h5555; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      n_done = 0;
      got_s  = 16'h0;
      repeat (12) begin
         if (done) begin
            n_done++;
            got_s = S;
         end
         @(posedge clk); @(negedge clk);
      end
      check("run_start:done_count", 32'(n_done), 32'(1));
      check("run_start:S", 32'(got_s), 32'(16'h0002));
      check("run_start:C_out", 32'(C_out), 32'(0));
      check("run_start:Ofl", 32'(Ofl), 32'(0));
`ifdef SERIAL_ADDER_ERR_EN
      check("run_start:err", 32'(err), 32'(1));
      repeat (3) @(negedge clk);
      check("run_start:err_sticky", 32'(err), 32'(1));
`endif

      // Reset in the second RUN cycle abandons the operation.
      A = 16'h1357; B = 16'h2468; C_in = 1'b1; sub = 1'b0; start = 1'b1;
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      check("mid_rst:busy", 32'(busy), 32'(0));
      check("mid_rst:done", 32'(done), 32'(0));
      check("mid_rst:S", 32'(S), 32'(0));
      check("mid_rst:C_out", 32'(C_out), 32'(0));
      check("mid_rst:Ofl", 32'(Ofl), 32'(0));
`ifdef SERIAL_ADDER_ERR_EN
      check("mid_rst:err", 32'(err), 32'(0));
`endif
      rst = 1'b0;
      n_done = 0;
      repeat (8) begin
         if (done) n_done++;
         @(posedge clk); @(negedge clk);
      end
      check("mid_rst:no_done", 32'(n_done), 32'(0));
      hold_s = 16'h0; hold_co = 1'b0; hold_of = 1'b0;
      run_and_check("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      // Random operations against the reference model, mixing corner operands.
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 5))
            0:       ra = 16'h8000;
            1:       ra = 16'h7FFF;
            2:       ra = 16'hFFFF;
            default: ra = 16'($urandom);
         endcase
         case ($urandom_range(0, 4))
            0:       rb = 16'h0000;
            1:       rb = 16'h8000;
            default: rb = 16'($urandom);
         endcase
         rci = 1'($urandom);
         rsb = 1'($urandom);
         model(ra, rb, rci, rsb, ms, mco, mof);
         run_and_check($sformatf("rnd%0d", k), ra, rb, rci, rsb, ms, mco, mof);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
